// File: rtl/cu_pkg.sv
// cu_pkg: shared types and encodings for the multi-cycle CPU control unit.
package cu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_HALT      = 3'd4
  } state_e;

  // Instruction classes produced by the opcode decoder
  typedef enum logic [2:0] {
    CL_NOP     = 3'd0,
    CL_LOAD    = 3'd1,
    CL_MOV     = 3'd2,
    CL_OUT     = 3'd3,
    CL_ALU     = 3'd4,
    CL_HALT    = 3'd5,
    CL_ILLEGAL = 3'd6
  } op_class_e;

  localparam logic [3:0] OP_NOP      = 4'h0;
  localparam logic [3:0] OP_LOAD     = 4'h1;
  localparam logic [3:0] OP_MOV      = 4'h2;
  localparam logic [3:0] OP_OUT      = 4'h3;
  localparam logic [3:0] OP_ALU_BASE = 4'h4;
  localparam logic [3:0] OP_ALU_LAST = 4'hB;
  localparam logic [3:0] OP_HALT     = 4'hF;

  localparam logic [1:0] BSEL_EXT = 2'b00;
  localparam logic [1:0] BSEL_REG = 2'b01;
  localparam logic [1:0] BSEL_ALU = 2'b10;

endpackage

// File: rtl/cpu_control_fsm_if.sv
// cpu_control_fsm_if: control bus from the control unit to the datapath.
interface cpu_control_fsm_if #(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned F_SEL_W  = 4
);
  logic [NUM_REGS-1:0]         wr_en;
  logic                        write_o;
  logic [F_SEL_W-1:0]          F_sel;
  logic [1:0]                  B_sel;
  logic [$clog2(NUM_REGS)-1:0] rd_sel;

  modport master (output wr_en, write_o, F_sel, B_sel, rd_sel);
  modport slave  (input  wr_en, write_o, F_sel, B_sel, rd_sel);
endinterface

// File: rtl/cu_btn_edge.sv
// cu_btn_edge: two-flop synchroniser plus rising-edge detector for ex_btn.
module cu_btn_edge (
  input  logic clk,
  input  logic rstn,
  input  logic ex_btn,
  output logic step
);
  // [0],[1] synchronise, [2] remembers the previous synchronised level
  logic [2:0] sync_q, sync_d;

  // Shift the button level through the synchroniser/history chain
  always_comb begin
    sync_d = {sync_q[1:0], ex_btn};
  end

  // Synchroniser registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  assign step = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle Moore control unit for the teaching CPU.
// Optional feature macro: CU_ILLEGAL_TRAP_EN (illegal opcodes trap into HALT).
module cpu_control_fsm
  import cu_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned F_SEL_W  = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        ex_btn,
  input  logic [OPCODE_W-1:0]         opcode,
  input  logic [$clog2(NUM_REGS)-1:0] dst,
  input  logic [$clog2(NUM_REGS)-1:0] src,
  cpu_control_fsm_if.master           dp,
  output logic                        busy,
  output logic                        halted,
  output logic [CNT_W-1:0]            retired
);
  localparam int unsigned IDX_W = $clog2(NUM_REGS);

  logic                step;
  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] ir_op_q, ir_op_d;
  logic [IDX_W-1:0]    ir_dst_q, ir_dst_d;
  logic [IDX_W-1:0]    ir_src_q, ir_src_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic [NUM_REGS-1:0] wr_en_q, wr_en_d;
  logic                write_o_q, write_o_d;
  logic [F_SEL_W-1:0]  f_sel_q, f_sel_d;
  logic [1:0]          b_sel_q, b_sel_d;
  logic [IDX_W-1:0]    rd_sel_q, rd_sel_d;
  logic                busy_q, busy_d;
  logic                halted_q, halted_d;
  op_class_e           op_cls;
  logic [3:0]          op_lo;
  logic [2:0]          alu_fn;

  cu_btn_edge u_btn_edge (
    .clk    (clk),
    .rstn   (rstn),
    .ex_btn (ex_btn),
    .step   (step)
  );

  // Classify the latched opcode; any nonzero bit above the low nibble is illegal
  always_comb begin
    op_lo  = ir_op_q[3:0];
    alu_fn = 3'(op_lo - OP_ALU_BASE);
    op_cls = CL_ILLEGAL;
    if ((ir_op_q >> 4) == '0) begin
      if (op_lo == OP_NOP)       op_cls = CL_NOP;
      else if (op_lo == OP_LOAD) op_cls = CL_LOAD;
      else if (op_lo == OP_MOV)  op_cls = CL_MOV;
      else if (op_lo == OP_OUT)  op_cls = CL_OUT;
      else if (op_lo == OP_HALT) op_cls = CL_HALT;
      else if (op_lo >= OP_ALU_BASE && op_lo <= OP_ALU_LAST) op_cls = CL_ALU;
    end
  end

  // Next-state, instruction register capture and retire counting
  always_comb begin
    state_d   = state_q;
    ir_op_d   = ir_op_q;
    ir_dst_d  = ir_dst_q;
    ir_src_d  = ir_src_q;
    retired_d = retired_q;
    case (state_q)
      ST_IDLE: begin
        if (step) begin
          state_d  = ST_DECODE;
          ir_op_d  = opcode;
          ir_dst_d = dst;
          ir_src_d = src;
        end
      end
      ST_DECODE: begin
        if (op_cls == CL_HALT) state_d = ST_HALT;
`ifdef CU_ILLEGAL_TRAP_EN
        else if (op_cls == CL_ILLEGAL) state_d = ST_HALT;
`endif
        else state_d = ST_EXECUTE;
      end
      ST_EXECUTE:   state_d = ST_WRITEBACK;
      ST_WRITEBACK: begin
        state_d   = ST_IDLE;
        retired_d = retired_q + CNT_W'(1);
      end
      ST_HALT:      state_d = ST_HALT;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output is a flop
  always_comb begin
    f_sel_d   = '0;
    b_sel_d   = BSEL_EXT;
    rd_sel_d  = '0;
    wr_en_d   = '0;
    write_o_d = 1'b0;
    busy_d    = (state_d != ST_IDLE);
    halted_d  = (state_d == ST_HALT);
    if (state_d == ST_EXECUTE || state_d == ST_WRITEBACK) begin
      case (op_cls)
        CL_MOV, CL_OUT: begin
          b_sel_d  = BSEL_REG;
          rd_sel_d = ir_src_q;
        end
        CL_ALU: begin
          f_sel_d  = F_SEL_W'(alu_fn);
          b_sel_d  = BSEL_ALU;
          rd_sel_d = ir_src_q;
        end
        default: ;
      endcase
    end
    if (state_d == ST_WRITEBACK) begin
      if (op_cls == CL_LOAD || op_cls == CL_MOV || op_cls == CL_ALU)
        wr_en_d = NUM_REGS'(1) << ir_dst_q;
      if (op_cls == CL_OUT)
        write_o_d = 1'b1;
    end
  end

  // State, instruction register, counter and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      ir_op_q   <= '0;
      ir_dst_q  <= '0;
      ir_src_q  <= '0;
      retired_q <= '0;
      wr_en_q   <= '0;
      write_o_q <= 1'b0;
      f_sel_q   <= '0;
      b_sel_q   <= '0;
      rd_sel_q  <= '0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_op_q   <= ir_op_d;
      ir_dst_q  <= ir_dst_d;
      ir_src_q  <= ir_src_d;
      retired_q <= retired_d;
      wr_en_q   <= wr_en_d;
      write_o_q <= write_o_d;
      f_sel_q   <= f_sel_d;
      b_sel_q   <= b_sel_d;
      rd_sel_q  <= rd_sel_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
    end
  end

  assign dp.wr_en   = wr_en_q;
  assign dp.write_o = write_o_q;
  assign dp.F_sel   = f_sel_q;
  assign dp.B_sel   = b_sel_q;
  assign dp.rd_sel  = rd_sel_q;
  assign busy       = busy_q;
  assign halted     = halted_q;
  assign retired    = retired_q;
endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb_cpu_control_fsm: directed + randomized checks of cpu_control_fsm against
// a cycle-offset reference model derived from the instruction timeline.
module tb_cpu_control_fsm;

`ifdef CU_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam int K_NOP  = 0;
  localparam int K_LOAD = 1;
  localparam int K_MOV  = 2;
  localparam int K_OUT  = 3;
  localparam int K_ALU  = 4;
  localparam int K_HALT = 5;
  localparam int K_ILL  = 6;

  logic       clk = 1'b0;
  logic       rstn;
  logic       ex_btn;
  logic [3:0] opcode;
  logic [1:0] dst, src;
  logic       busy, halted;
  logic [7:0] retired;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_retired = 8'd0;
  bit         m_halted  = 1'b0;

  cpu_control_fsm_if #(.NUM_REGS(4), .F_SEL_W(4)) dp ();

  cpu_control_fsm #(
    .OPCODE_W (4),
    .NUM_REGS (4),
    .F_SEL_W  (4),
    .CNT_W    (8)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .ex_btn  (ex_btn),
    .opcode  (opcode),
    .dst     (dst),
    .src     (src),
    .dp      (dp),
    .busy    (busy),
    .halted  (halted),
    .retired (retired)
  );

  always #5 clk = ~clk;

  function automatic int kind_of(input logic [3:0] op);
    if (op == 4'h0) return K_NOP;
    if (op == 4'h1) return K_LOAD;
    if (op == 4'h2) return K_MOV;
    if (op == 4'h3) return K_OUT;
    if (op >= 4'h4 && op <= 4'hB) return K_ALU;
    if (op == 4'hF) return K_HALT;
    return K_ILL;
  endfunction

  function automatic bit stops(input int k);
    return (k == K_HALT) || (TRAP && k == K_ILL);
  endfunction

  function automatic logic [22:0] pack(input logic b, input logic h, input logic [3:0] w,
                                       input logic wo, input logic [3:0] f, input logic [1:0] bs,
                                       input logic [1:0] rs, input logic [7:0] ret);
    return {b, h, w, wo, f, bs, rs, ret};
  endfunction

  // Expected outputs n cycles after the edge that first samples the press
  function automatic logic [22:0] expect_at(input int n, input logic [3:0] op, input logic [1:0] d,
                                            input logic [1:0] s, input logic [7:0] ret, input bit hb);
    int         k;
    logic [3:0] w, f;
    logic       wo;
    logic [1:0] bs, rs;
    k = kind_of(op);
    if (hb)       return pack(1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 2'd0, 2'd0, ret);
    if (n < 2)    return pack(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 2'd0, 2'd0, ret);
    if (n == 2)   return pack(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 2'd0, 2'd0, ret);
    if (stops(k)) return pack(1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 2'd0, 2'd0, ret);
    if (n >= 5)   return pack(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 2'd0, 2'd0, ret + 8'd1);
    w = 4'd0; f = 4'd0; wo = 1'b0; bs = 2'd0; rs = 2'd0;
    case (k)
      K_MOV, K_OUT: begin bs = 2'b01; rs = s; end
      K_ALU:        begin f = op - 4'd4; bs = 2'b10; rs = s; end
      default: ;
    endcase
    if (n == 4) begin
      if (k == K_LOAD || k == K_MOV || k == K_ALU) w = 4'b0001 << d;
      if (k == K_OUT) wo = 1'b1;
    end
    return pack(1'b1, 1'b0, w, wo, f, bs, rs, ret);
  endfunction

  task automatic chk(input string tag, input logic [22:0] exp);
    logic [22:0] got;
    got = {busy, halted, dp.wr_en, dp.write_o, dp.F_sel, dp.B_sel, dp.rd_sel, retired};
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h (busy,halted,wr_en,write_o,F_sel,B_sel,rd_sel,retired)",
             tag, got, exp);
    end
  endtask

  // Press the button for 'hold' cycles and check every cycle of the instruction
  task automatic run_instr(input string tag, input logic [3:0] op, input logic [1:0] d,
                           input logic [1:0] s, input int hold, input bit repress,
                           input bit scramble);
    int         last;
    bit         hb;
    logic [7:0] ret;
    hb   = m_halted;
    ret  = m_retired;
    last = (hold + 3 > 6) ? hold + 3 : 6;
    opcode = op; dst = d; src = s; ex_btn = 1'b1;
    for (int n = 0; n <= last; n++) begin
      @(posedge clk);
      @(negedge clk);
      ex_btn = (n + 1 < hold) || (repress && n == 2);
      if (scramble && n >= 2) begin
        opcode = 4'($urandom);
        dst    = 2'($urandom);
        src    = 2'($urandom);
      end
      chk(tag, expect_at(n, op, d, s, ret, hb));
    end
    if (!hb) begin
      if (stops(kind_of(op))) m_halted = 1'b1;
      else                    m_retired = m_retired + 8'd1;
    end
    ex_btn = 1'b0;
  endtask

  task automatic pulse_reset(input string tag);
    rstn = 1'b0;
    #1;
    chk(tag, 23'd0);
    #2;
    rstn = 1'b1;
    m_retired = 8'd0;
    m_halted  = 1'b0;
  endtask

  initial begin
    logic [3:0] rop;
    logic [1:0] rs;
    rstn = 1'b0; ex_btn = 1'b0; opcode = 4'h0; dst = 2'd0; src = 2'd0;

    // Reset held, then released at 35 ns
    repeat (3) begin
      @(negedge clk);
      chk("reset_hold", 23'd0);
    end
    #5 rstn = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("reset_idle", 23'd0);
    end

    run_instr("load", 4'h1, 2'd2, 2'd0, 1, 1'b0, 1'b0);
    run_instr("alu_repress", 4'h7, 2'd3, 2'd1, 1, 1'b1, 1'b0);

    // Randomized legal instruction mix
    for (int i = 0; i < 16; i++) begin
      run_instr("rand_mix", 4'($urandom_range(0, 11)), 2'($urandom), 2'($urandom),
                int'($urandom_range(1, 4)), 1'($urandom), 1'($urandom));
    end

    // Reset during EXECUTE of OUT aborts with no strobe
    rs = 2'($urandom);
    opcode = 4'h3; dst = 2'd0; src = rs; ex_btn = 1'b1;
    for (int n = 0; n <= 3; n++) begin
      @(posedge clk);
      @(negedge clk);
      ex_btn = 1'b0;
      chk("abort_pre", expect_at(n, 4'h3, 2'd0, rs, m_retired, 1'b0));
    end
    pulse_reset("abort_rst");
    repeat (5) begin
      @(negedge clk);
      chk("abort_post", 23'd0);
    end

    // 256 NOPs wrap the counter back to zero
    for (int i = 0; i < 256; i++) begin
      run_instr("wrap", 4'h0, 2'($urandom), 2'($urandom), 1, 1'b0, 1'b0);
    end
    chk("wrap_zero", pack(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 2'd0, 2'd0, 8'd0));

    run_instr("hold20", 4'h1, 2'($urandom), 2'($urandom), 20, 1'b0, 1'b0);

    // Illegal opcode, then presses that are ignored only if it trapped
    run_instr("illegal", 4'hD, 2'($urandom), 2'($urandom), 1, 1'b0, 1'b0);
    rop = 4'($urandom_range(4, 11));
    run_instr("after_illegal", rop, 2'($urandom), 2'($urandom), 1, 1'b0, 1'b0);

    // HALT is sticky
    @(negedge clk);
    pulse_reset("reset_pre_halt");
    repeat (2) @(negedge clk);
    run_instr("halt", 4'hF, 2'($urandom), 2'($urandom), 1, 1'b0, 1'b0);
    run_instr("halted_load", 4'h1, 2'd1, 2'd0, 1, 1'b0, 1'b0);
    run_instr("halted_alu", 4'h5, 2'd0, 2'd2, 3, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_control_fsm.md
# cpu_control_fsm

Parametrised multi-cycle control unit for the teaching CPU, successor to the single-cycle opcode decoder. Latches one instruction (opcode, destination, source) per debounced `ex_btn` press, then steps a Moore FSM through DECODE, EXECUTE and WRITEBACK. It drives ALU function select, bus select, a one-hot register write vector and the output-register strobe. It sits between the switch/button front panel and the datapath (register file, ALU, output register).

## Interface
- `OPCODE_W`, 4, opcode width; must be ≥4.
- `NUM_REGS`, 4, datapath register count; must be ≥2.
- `F_SEL_W`, 4, ALU function select width; must be ≥3.
- `CNT_W`, 8, retired-instruction counter width.
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `ex_btn` in 1: asynchronous execute button, level.
- `opcode` in OPCODE_W: instruction opcode.
- `dst` in $clog2(NUM_REGS): destination register index.
- `src` in $clog2(NUM_REGS): source register index.
- `wr_en` out NUM_REGS: one-hot register write strobe.
- `write_o` out 1: output-register write strobe.
- `F_sel` out F_SEL_W: ALU function.
- `B_sel` out 2: bus source; 00 = external input, 01 = register read, 10 = ALU result.
- `rd_sel` out $clog2(NUM_REGS): register-file read index.
- `busy` out 1: state ≠ IDLE.
- `halted` out 1: state = HALT.
- `retired` out CNT_W: completed-instruction count.

## Operation
- `ex_btn` passes through a 2-flop synchroniser and a rising-edge detector, producing a one-cycle `step` pulse. Holding the button high yields exactly one `step`.
- **States:** IDLE, DECODE, EXECUTE, WRITEBACK, HALT.
- **IDLE:** on `step`, capture `opcode`, `dst`, `src` into the instruction register and go to DECODE.
- **DECODE:** classify the latched opcode, then go to EXECUTE. HALT opcode goes to HALT instead.
- **EXECUTE:** drive `F_sel`, `B_sel`, `rd_sel`, then go to WRITEBACK.
- **WRITEBACK:** hold the selects, pulse the write strobe for one cycle, increment `retired` (wraps modulo 2^CNT_W), then go to IDLE.
- **HALT:** sticky; left only through `rstn`. `retired` is not incremented.
- `step` arriving while `busy` or `halted` is dropped and not queued.
- **Opcode map:**
  - 0x0 NOP: no strobe, counted.
  - 0x1 LOAD: B_sel=00, `wr_en[dst]`.
  - 0x2 MOV: B_sel=01, rd_sel=src, `wr_en[dst]`.
  - 0x3 OUT: B_sel=01, rd_sel=src, `write_o`.
  - 0x4–0xB ALU: F_sel = opcode−4 (zero-extended), B_sel=10, rd_sel=src, `wr_en[dst]`.
  - 0xF HALT.
  - 0xC–0xE, and any code above 0xF when OPCODE_W>4, are illegal.
- Outputs outside EXECUTE/WRITEBACK: `F_sel`, `B_sel`, `rd_sel` = 0. `wr_en` and `write_o` are 0 outside WRITEBACK.

## Timing
- **Reset:** all outputs 0, state IDLE, synchroniser flops cleared, instruction register cleared. Reset is asynchronous assert; deassert is sampled at the next rising edge.
- **Latency:** if `ex_btn` rises before edge k, then `step` is high in cycle k+1..k+2, DECODE starts at k+2, EXECUTE at k+3, WRITEBACK at k+4, IDLE at k+5. `retired` updates at k+5.
- Reset asserted mid-instruction aborts it: no strobe, `retired` is unchanged from its cleared value of 0.
- Instruction inputs are sampled only on the IDLE→DECODE transition. Later changes have no effect.
- All outputs are registered or decoded purely from state plus the instruction register; there are no combinational paths from inputs.

## Configuration
- **With `CU_ILLEGAL_TRAP_EN` defined:** an illegal opcode goes DECODE→HALT, `halted`=1, not counted.
- **Without it:** an illegal opcode executes as NOP, through EXECUTE/WRITEBACK with no strobes, and is counted.

## Structure
- **Package `cu_pkg`:** state enum, opcode constants (OP_NOP, OP_LOAD, OP_MOV, OP_OUT, OP_ALU_BASE, OP_ALU_LAST, OP_HALT), B_sel encodings (BSEL_EXT, BSEL_REG, BSEL_ALU).
- **Sub-module `cu_btn_edge`:** synchroniser plus rising-edge detector with `clk`/`rstn`, output `step`.
- Top level holds the FSM, instruction register, output decode and `retired` counter.

## Test plan
- **Reset:** assert `rstn`=0 at 0 ns, release at 35 ns → all outputs 0 and `busy`=0 throughout.
- **LOAD:** opcode=0x1, dst=2, press `ex_btn` → `wr_en`=4'b0100 for exactly one cycle at k+4 with B_sel=00, then `retired`=1.
- **ALU:** opcode=0x7, src=1, dst=3 → F_sel=4'b0011, B_sel=10, rd_sel=1 in EXECUTE and WRITEBACK, `wr_en`=4'b1000. A second press during `busy` is ignored and `retired` increments by 1 only.
- **HALT/illegal:** opcode=0xF → `halted`=1 and subsequent presses are ignored. Opcode=0xD → HALT with `CU_ILLEGAL_TRAP_EN` defined, NOP plus count without it.
- **Wrap:** 256 NOP presses with CNT_W=8 → `retired` returns to 0. Holding `ex_btn` high for 20 cycles → exactly one instruction.
- **Abort:** `rstn` pulsed low during EXECUTE of OUT → `write_o` never asserts, state IDLE, `retired`=0.
